// File: rtl/sparc_ifu_pcinc_arb_pkg.sv
// Shared IFU definitions for the per-thread PC sequencer.
//   IFU_PC_W : PC width in bits
//   IFU_NTHR : hardware thread count
//   tid_t    : thread identifier
//   HOLE_BIT : PC bit whose 0->1 transition on increment marks an address-hole crossing
package sparc_ifu_pcinc_arb_pkg;

    localparam int IFU_PC_W = 46;
    localparam int IFU_NTHR = 4;
    localparam int HOLE_BIT = IFU_PC_W - 1;

    typedef logic [1:0] tid_t;

endpackage

// File: rtl/sparc_ifu_incr46.sv
// Shared PC incrementer.
//   a     : PC selected by the arbiter
//   a_inc : a + 1, wrapping modulo 2^IFU_PC_W
//   ofl   : increment carried into the top bit (crossed into the address hole)
module sparc_ifu_incr46
    import sparc_ifu_pcinc_arb_pkg::*;
(
    input  logic [IFU_PC_W-1:0] a,
    output logic [IFU_PC_W-1:0] a_inc,
    output logic                ofl
);

    assign a_inc = a + {{(IFU_PC_W-1){1'b0}}, 1'b1};

    // Top bit going 0->1 is a hole crossing; 1->0 is a plain wrap and is not flagged.
    assign ofl = ~a[HOLE_BIT] & a_inc[HOLE_BIT];

endmodule

// File: rtl/sparc_ifu_pcinc_arb.sv
// Per-thread PC sequencer: four thread PCs share one incrementer, granted
// round-robin at most once per cycle. Redirect loads and a sticky overflow
// flag per thread make a thread ineligible for increment.
//   rclk, rst_l     : clock, synchronous active-low reset
//   inc_req         : per-thread increment request
//   ld_vld, ld_pc   : per-thread redirect strobe, shared redirect target
//   ofl_clr         : per-thread clear of the sticky overflow flag
//   inc_gnt         : one-hot grant, combinational in the request cycle
//   pc_t0..pc_t3    : registered thread PCs
//   ofl_t           : registered sticky overflow flags
module sparc_ifu_pcinc_arb
    import sparc_ifu_pcinc_arb_pkg::*;
#(
    parameter logic [IFU_PC_W-1:0] RESET_PC = '0,
    parameter int                  NTHR     = IFU_NTHR
) (
    input  logic                rclk,
    input  logic                rst_l,
    input  logic [NTHR-1:0]     inc_req,
    input  logic [NTHR-1:0]     ld_vld,
    input  logic [IFU_PC_W-1:0] ld_pc,
    input  logic [NTHR-1:0]     ofl_clr,
    output logic [NTHR-1:0]     inc_gnt,
    output logic [IFU_PC_W-1:0] pc_t0,
    output logic [IFU_PC_W-1:0] pc_t1,
    output logic [IFU_PC_W-1:0] pc_t2,
    output logic [IFU_PC_W-1:0] pc_t3,
    output logic [NTHR-1:0]     ofl_t
);

    logic [NTHR-1:0][IFU_PC_W-1:0] pc_q, pc_d;
    logic [NTHR-1:0]               ofl_q, ofl_d;
    tid_t                          ptr_q, ptr_d;

    logic [NTHR-1:0]               elig;
    logic                          found;
    logic                          gnt_vld;
    tid_t                          win;
    tid_t                          idx;
    logic [IFU_PC_W-1:0]           inc_a;
    logic [IFU_PC_W-1:0]           inc_res;
    logic                          inc_ofl;

    // A thread being redirected this cycle loses its increment to the load.
    assign elig = inc_req & ~ofl_q & ~ld_vld;

    // Round-robin pick: first eligible thread scanning from ptr_q upward.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < NTHR; k++) begin
            idx = ptr_q + tid_t'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant is suppressed during reset so nothing downstream sees a stray pick.
    assign gnt_vld = found & rst_l;

    always_comb begin
        inc_gnt = '0;
        if (gnt_vld) inc_gnt[win] = 1'b1;
    end

    assign inc_a = pc_q[win];

    sparc_ifu_incr46 u_incr (
        .a     (inc_a),
        .a_inc (inc_res),
        .ofl   (inc_ofl)
    );

    always_comb begin
        pc_d  = pc_q;
        ofl_d = ofl_q & ~ofl_clr;
        ptr_d = ptr_q;
        if (gnt_vld) begin
            pc_d[win] = inc_res;
            ptr_d     = win + tid_t'(1);
            // Setting after the clear lets a same-cycle set win.
            if (inc_ofl) ofl_d[win] = 1'b1;
        end
        for (int i = 0; i < NTHR; i++) begin
            if (ld_vld[i]) pc_d[i] = ld_pc;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            for (int i = 0; i < NTHR; i++) pc_q[i] <= RESET_PC;
            ofl_q <= '0;
            ptr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ofl_q <= ofl_d;
            ptr_q <= ptr_d;
        end
    end

    assign pc_t0 = pc_q[0];
    assign pc_t1 = pc_q[1];
    assign pc_t2 = pc_q[2];
    assign pc_t3 = pc_q[3];
    assign ofl_t = ofl_q;

endmodule

// File: tb/tb_sparc_ifu_pcinc_arb.sv
module tb_sparc_ifu_pcinc_arb;

    localparam logic [45:0] RST_PC = 46'h0000_0000_1000;
    localparam logic [45:0] HOLE   = 46'h2000_0000_0000;

    logic        rclk = 1'b0;
    logic        rst_l;
    logic [3:0]  inc_req, ld_vld, ofl_clr;
    logic [45:0] ld_pc;
    logic [3:0]  inc_gnt, ofl_t;
    logic [45:0] pc_t0, pc_t1, pc_t2, pc_t3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [45:0] m_pc [4];
    logic [3:0]  m_ofl;
    int          m_ptr;
    logic [3:0]  last_gnt;

    always #5 rclk = ~rclk;

    sparc_ifu_pcinc_arb #(.RESET_PC(RST_PC), .NTHR(4)) dut (
        .rclk    (rclk),
        .rst_l   (rst_l),
        .inc_req (inc_req),
        .ld_vld  (ld_vld),
        .ld_pc   (ld_pc),
        .ofl_clr (ofl_clr),
        .inc_gnt (inc_gnt),
        .pc_t0   (pc_t0),
        .pc_t1   (pc_t1),
        .pc_t2   (pc_t2),
        .pc_t3   (pc_t3),
        .ofl_t   (ofl_t)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [45:0] dut_pc(input int t);
        case (t)
            0: return pc_t0;
            1: return pc_t1;
            2: return pc_t2;
            default: return pc_t3;
        endcase
    endfunction

    // Round-robin search expressed directly from the rules: the first thread
    // at distance 0..3 from the pointer that wants and may advance.
    function automatic int m_pick(input logic [3:0] req, input logic [3:0] ld);
        for (int k = 0; k < 4; k++) begin
            int t;
            t = (m_ptr + k) % 4;
            if (req[t] && !m_ofl[t] && !ld[t]) return t;
        end
        return -1;
    endfunction

    // One clock: drive, check grant mid-cycle, advance model, check state after the edge.
    task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] ld,
                       input logic [45:0] lpc, input logic [3:0] clr);
        int          w;
        logic [3:0]  eg;
        logic [3:0]  nofl;
        logic [45:0] nxt;
        rst_l = rst; inc_req = req; ld_vld = ld; ld_pc = lpc; ofl_clr = clr;
        w  = rst ? m_pick(req, ld) : -1;
        eg = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        @(negedge rclk);
        last_gnt = inc_gnt;
        chk("gnt", {60'd0, inc_gnt}, {60'd0, eg});
        @(posedge rclk);
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_pc[i] = RST_PC;
            m_ofl = 4'b0;
            m_ptr = 0;
        end else begin
            nofl = m_ofl & ~clr;
            if (w >= 0) begin
                nxt = m_pc[w] + 46'd1;
                if (m_pc[w] < HOLE && nxt >= HOLE) nofl[w] = 1'b1;
                m_pc[w] = nxt;
                m_ptr   = (w + 1) % 4;
            end
            for (int i = 0; i < 4; i++) if (ld[i]) m_pc[i] = lpc;
            m_ofl = nofl;
        end
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("pc%0d", i), {18'd0, dut_pc(i)}, {18'd0, m_pc[i]});
        chk("ofl", {60'd0, ofl_t}, {60'd0, m_ofl});
    endtask

    function automatic logic [45:0] rnd_pc();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return HOLE - 46'd1 - 46'($urandom_range(0, 2));
            1: return 46'h3FFF_FFFF_FFFF - 46'($urandom_range(0, 2));
            default: return r[45:0];
        endcase
    endfunction

    initial begin
        rst_l = 1'b0; inc_req = '0; ld_vld = '0; ld_pc = '0; ofl_clr = '0;
        m_ptr = 0; m_ofl = '0;
        for (int i = 0; i < 4; i++) m_pc[i] = RST_PC;
        @(posedge rclk); #1;

        // Reset with requests pending: no grant, reset values.
        cyc(1'b0, 4'b1111, 4'b0, 46'd0, 4'b0);
        cyc(1'b0, 4'b0000, 4'b0, 46'd0, 4'b0);
        chk("rst_pc0", {18'd0, pc_t0}, {18'd0, RST_PC});
        chk("rst_ofl", {60'd0, ofl_t}, 64'd0);

        // All threads requesting: strict rotation, two increments each.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 4'b1111, 4'b0, 46'd0, 4'b0);
            chk("rr_seq", {60'd0, last_gnt}, {60'd0, 4'b0001 << (i % 4)});
        end
        chk("rr_pc3", {18'd0, pc_t3}, {18'd0, RST_PC + 46'd2});

        // Hole crossing on thread 2, blocked while flagged, resumes after clear.
        cyc(1'b1, 4'b0000, 4'b0100, HOLE - 46'd1, 4'b0);
        cyc(1'b1, 4'b0100, 4'b0000, 46'd0, 4'b0);
        chk("hole_pc2", {18'd0, pc_t2}, {18'd0, HOLE});
        chk("hole_ofl2", {63'd0, ofl_t[2]}, 64'd1);
        cyc(1'b1, 4'b0100, 4'b0000, 46'd0, 4'b0);
        chk("hole_blk", {60'd0, last_gnt}, 64'd0);
        chk("hole_pc2h", {18'd0, pc_t2}, {18'd0, HOLE});
        cyc(1'b1, 4'b0000, 4'b0000, 46'd0, 4'b0100);
        cyc(1'b1, 4'b0100, 4'b0000, 46'd0, 4'b0);
        chk("hole_res", {60'd0, last_gnt}, 64'h4);

        // Full wrap on thread 1 is not an overflow.
        cyc(1'b1, 4'b0000, 4'b0010, 46'h3FFF_FFFF_FFFF, 4'b0);
        cyc(1'b1, 4'b0010, 4'b0000, 46'd0, 4'b0);
        chk("wrap_pc1", {18'd0, pc_t1}, 64'd0);
        chk("wrap_ofl1", {63'd0, ofl_t[1]}, 64'd0);

        // Load beats increment on thread 0; pointer lands on 2.
        cyc(1'b0, 4'b0000, 4'b0, 46'd0, 4'b0);
        cyc(1'b1, 4'b0011, 4'b0001, 46'h100, 4'b0);
        chk("ld_gnt", {60'd0, last_gnt}, 64'h2);
        chk("ld_pc0", {18'd0, pc_t0}, 64'h100);
        chk("ld_pc1", {18'd0, pc_t1}, {18'd0, RST_PC + 46'd1});
        cyc(1'b1, 4'b0111, 4'b0000, 46'd0, 4'b0);
        chk("ld_ptr", {60'd0, last_gnt}, 64'h4);

        // Set and clear on thread 3 in the same cycle: set wins.
        cyc(1'b1, 4'b0000, 4'b1000, HOLE - 46'd1, 4'b0);
        cyc(1'b1, 4'b1000, 4'b0000, 46'd0, 4'b1000);
        chk("sc_ofl3", {63'd0, ofl_t[3]}, 64'd1);
        cyc(1'b1, 4'b1000, 4'b0000, 46'd0, 4'b0);
        chk("sc_blk", {60'd0, last_gnt}, 64'd0);

        // Reset while a grant would be issued.
        cyc(1'b1, 4'b0010, 4'b0000, 46'd0, 4'b0);
        cyc(1'b0, 4'b1111, 4'b0000, 46'd0, 4'b0);
        chk("mrst_pc2", {18'd0, pc_t2}, {18'd0, RST_PC});
        chk("mrst_ofl", {60'd0, ofl_t}, 64'd0);
        cyc(1'b1, 4'b1111, 4'b0000, 46'd0, 4'b0);
        chk("mrst_ptr", {60'd0, last_gnt}, 64'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic [3:0]  rq, ld, cl;
            r  = ($urandom_range(0, 99) != 0);
            rq = 4'($urandom);
            ld = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            cl = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
            cyc(r, rq, ld, rnd_pc(), cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
